// File: rtl/keypad_key_fifo_pkg.sv
// Shared definitions for the keypad key FIFO: key code width and the
// qualifier state encoding (same encoding the scanner side uses).
package keypad_key_fifo_pkg;

  localparam int KEY_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_QUALIFY = 2'd1,
    ST_HELD    = 2'd2,
    ST_RELEASE = 2'd3
  } qual_state_e;

endpackage

// File: rtl/keypad_key_fifo_sync_fifo.sv
// keypad_sync_fifo: single-clock first-word-fall-through FIFO.
//   clock, reset   rising-edge clock, async active-low reset
//   push, wdata    write request / data (ignored when full unless popping)
//   pop            read request (ignored when empty)
//   rdata          head entry, 0 when empty
//   full, empty    occupancy flags
//   count          occupancy, reaches DEPTH when full
module keypad_sync_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);   // wraps: DEPTH is a power of 2
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/keypad_key_fifo.sv
// keypad_key_fifo: debounces scanner output into one event per press and
// queues events for the consumer.
//   clock, reset          rising-edge clock, async active-low reset
//   key_data, key_v       scan code and "key detected" from the scanner
//   out_data, out_valid   FIFO head / non-empty
//   out_ready             consumer takes head when out_valid && out_ready
//   count                 FIFO occupancy
//   overflow, clear_ovf   sticky dropped-press flag and its clear (set wins)
module keypad_key_fifo
  import keypad_key_fifo_pkg::*;
#(
  parameter int HOLD_CYCLES    = 3,
  parameter int RELEASE_CYCLES = 2,
  parameter int DEPTH          = 8,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [KEY_W-1:0] key_data,
  input  logic             key_v,
  output logic [KEY_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    count,
  output logic             overflow,
  input  logic             clear_ovf
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int RW = $clog2(RELEASE_CYCLES + 1);

  qual_state_e      state, state_n;
  logic [HW-1:0]    hold_cnt, hold_n;
  logic [RW-1:0]    rel_cnt, rel_n;
  logic [KEY_W-1:0] key_lat, lat_n;
  logic             accept, full, empty, pop;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      hold_cnt <= '0;
      rel_cnt  <= '0;
      key_lat  <= '0;
    end else begin
      state    <= state_n;
      hold_cnt <= hold_n;
      rel_cnt  <= rel_n;
      key_lat  <= lat_n;
    end
  end

  always_comb begin
    state_n = state;
    hold_n  = hold_cnt;
    rel_n   = rel_cnt;
    lat_n   = key_lat;
    accept  = 1'b0;
    case (state)
      ST_IDLE: if (key_v) begin
        lat_n  = key_data;
        hold_n = HW'(1);
        if (HOLD_CYCLES == 1) begin
          accept  = 1'b1;
          state_n = ST_HELD;
        end else begin
          state_n = ST_QUALIFY;
        end
      end
      ST_QUALIFY: begin
        if (!key_v) begin
          state_n = ST_IDLE;               // glitch: too short to count
          hold_n  = '0;
        end else if (key_data != key_lat) begin
          lat_n  = key_data;               // code changed: restart the hold window
          hold_n = HW'(1);
        end else begin
          hold_n = hold_cnt + HW'(1);
          if (hold_cnt == HW'(HOLD_CYCLES - 1)) begin
            accept  = 1'b1;
            state_n = ST_HELD;
          end
        end
      end
      ST_HELD: if (!key_v) begin
        rel_n   = RW'(1);
        state_n = (RELEASE_CYCLES == 1) ? ST_IDLE : ST_RELEASE;
      end
      ST_RELEASE: begin
        if (key_v) begin
          state_n = ST_HELD;               // contact bounce, same press
        end else begin
          rel_n = rel_cnt + RW'(1);
          if (rel_cnt == RW'(RELEASE_CYCLES - 1)) state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign out_valid = ~empty;
  assign pop       = out_valid & out_ready;

  keypad_sync_fifo #(.WIDTH(KEY_W), .DEPTH(DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (accept),
    .wdata (key_lat_push()),
    .pop   (pop),
    .rdata (out_data),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // The pushed code is the one being latched on the accept edge; in QUALIFY it
  // equals key_lat, in IDLE (HOLD_CYCLES==1) it is the live input.
  function automatic logic [KEY_W-1:0] key_lat_push();
    return lat_n;
  endfunction

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                      overflow <= 1'b0;
    else if (accept & full & ~pop)   overflow <= 1'b1;
    else if (clear_ovf)              overflow <= 1'b0;
  end

endmodule

// File: tb/tb_keypad_key_fifo.sv
module tb_keypad_key_fifo;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] key_data;
  logic       key_v;
  logic [3:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] count;
  logic       overflow;
  logic       clear_ovf;

  int vectors = 0;
  int miscompares = 0;
  logic [3:0] sb[$];

  always #5 clock = ~clock;

  keypad_key_fifo dut (
    .clock     (clock),
    .reset     (reset),
    .key_data  (key_data),
    .key_v     (key_v),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count),
    .overflow  (overflow),
    .clear_ovf (clear_ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n cycles; inputs change only at negedge. Just before each rising
  // edge, a handshake that will pop is checked against the scoreboard.
  task automatic cyc(input int n = 1);
    for (int i = 0; i < n; i++) begin
      #1;
      if (out_valid && out_ready) begin
        chk("sb_has_entry", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) chk("pop_data", 32'(out_data), 32'(sb.pop_front()));
      end
      @(negedge clock);
    end
  endtask

  task automatic press(input logic [3:0] code, input int hold, input int low);
    key_v = 1'b1; key_data = code; cyc(hold);
    key_v = 1'b0; cyc(low);
  endtask

  initial begin
    reset = 1'b0; key_v = 1'b1; key_data = 4'h5; out_ready = 1'b0; clear_ovf = 1'b0;
    @(negedge clock); cyc(2);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data",  32'(out_data),  0);
    chk("rst_count", 32'(count),     0);
    chk("rst_ovf",   32'(overflow),  0);

    // 1: key held through reset release counts as a fresh press
    reset = 1'b1;
    cyc(2); chk("t1_not_yet", 32'(count), 0);
    cyc(1); sb.push_back(4'h5);
    chk("t1_count", 32'(count), 1);
    chk("t1_valid", 32'(out_valid), 1);
    chk("t1_head",  32'(out_data), 32'h5);
    key_v = 1'b0; out_ready = 1'b1; cyc(2); out_ready = 1'b0;
    chk("t1_drained", 32'(count), 0);

    // 2: short press rejected, long press yields one event
    press(4'h3, 2, 3);
    chk("t2_glitch", 32'(count), 0);
    press(4'h3, 10, 2); sb.push_back(4'h3);
    chk("t2_one_push", 32'(count), 1);
    out_ready = 1'b1; cyc(1); out_ready = 1'b0;

    // 3: bounce during release stays one event
    key_v = 1'b1; key_data = 4'h7; cyc(3); sb.push_back(4'h7);
    key_v = 1'b1; cyc(1);
    key_v = 1'b0; cyc(1);
    key_v = 1'b1; cyc(1);
    key_v = 1'b0; cyc(2);
    chk("t3_bounce", 32'(count), 1);
    press(4'h7, 3, 2); sb.push_back(4'h7);
    chk("t3_second", 32'(count), 2);
    out_ready = 1'b1; cyc(2); out_ready = 1'b0;
    chk("t3_drained", 32'(count), 0);

    // 4: nine presses into an 8-deep FIFO
    for (int k = 0; k < 9; k++) begin
      press(4'(k), 3, 2);
      if (k < 8) sb.push_back(4'(k));
    end
    chk("t4_count", 32'(count), 8);
    chk("t4_ovf",   32'(overflow), 1);
    chk("t4_head",  32'(out_data), 0);
    clear_ovf = 1'b1; cyc(1); clear_ovf = 1'b0;
    chk("t4_ovf_clr", 32'(overflow), 0);

    // 5: full FIFO with simultaneous push and pop
    key_v = 1'b1; key_data = 4'h9; cyc(2);
    out_ready = 1'b1; cyc(1); out_ready = 1'b0; sb.push_back(4'h9);
    chk("t5_count", 32'(count), 8);
    chk("t5_ovf",   32'(overflow), 0);
    chk("t5_head",  32'(out_data), 1);
    key_v = 1'b0; cyc(2);
    out_ready = 1'b1; cyc(8); out_ready = 1'b0;
    chk("t5_empty", 32'(count), 0);
    chk("t5_valid", 32'(out_valid), 0);
    chk("t5_data0", 32'(out_data), 0);

    // 6: code change mid-qualify restarts the hold window
    key_v = 1'b1; key_data = 4'h1; cyc(2);
    key_data = 4'h2; cyc(2);
    chk("t6_not_yet", 32'(count), 0);
    cyc(1); sb.push_back(4'h2);
    chk("t6_count", 32'(count), 1);
    chk("t6_head",  32'(out_data), 32'h2);
    key_v = 1'b0; cyc(2);
    out_ready = 1'b1; cyc(1); out_ready = 1'b0;

    // reset mid-operation discards contents; held key re-qualifies
    key_v = 1'b1; key_data = 4'hA; cyc(3);
    chk("rm_pre", 32'(count), 1);
    reset = 1'b0; cyc(1);
    chk("rm_cleared", 32'(count), 0);
    reset = 1'b1; cyc(2);
    chk("rm_requal", 32'(count), 0);
    cyc(1); sb.push_back(4'hA);
    chk("rm_count", 32'(count), 1);
    key_v = 1'b0; out_ready = 1'b1; cyc(2); out_ready = 1'b0;
    chk("sb_empty_end", 32'(sb.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
